// File: rtl/fma_pkg.sv
// fma_pkg: shared FMA datapath widths and resolver state encoding
package fma_pkg;
  function automatic int csa_w(input int length);
    return 2 * length + 1;
  endfunction
  function automatic int nch(input int w, input int chunk);
    return (w + chunk - 1) / chunk;
  endfunction
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rstate_t;
endpackage

// File: rtl/csa_chunk_adder.sv
// csa_chunk_adder: one CHUNK-bit slice of the carry-propagate adder
module csa_chunk_adder #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save pair into one word, CHUNK bits per cycle
module csa_resolver
  import fma_pkg::*;
#(
  parameter int LENGTH = 32,
  parameter int CHUNK = 16,
  localparam int W = csa_w(LENGTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sum_in,
  input  logic [W-1:0] carry_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] res,
  output logic         res_zero,
  output logic         res_neg,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int NCH = nch(W, CHUNK);
  localparam int PW = NCH * CHUNK;
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  rstate_t state, state_d;
  logic [PW-1:0] sum_q, car_q;
  logic [IW-1:0] idx;
  logic cy, zacc, last, cout, nz;
  logic [CHUNK-1:0] a, b, s;
  logic [W-1:0] res_d;
  assign last = idx == IW'(NCH - 1);
  assign a = CHUNK'(sum_q >> (int'(idx) * CHUNK));
  assign b = CHUNK'(car_q >> (int'(idx) * CHUNK));
  csa_chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a(a),
    .b(b),
    .cin(cy),
    .s(s),
    .cout(cout)
  );
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_d;
  // next state and handshake outputs
  always_comb begin
    state_d = state;
    state_d = (state == IDLE && in_valid) ? RUN :
              (state == RUN && last) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
    in_ready = state == IDLE && !rst;
    out_valid = state == DONE;
  end
  // merge the current chunk into the result and test its in-range bits for zero
  always_comb begin
    res_d = res;
    nz = 1'b0;
    for (int i = 0; i < W; i++) if (i / CHUNK == int'(idx)) res_d[i] = s[i % CHUNK];
    for (int j = 0; j < CHUNK; j++) if (int'(idx) * CHUNK + j < W) nz = nz | s[j];
  end
  // operand capture, chunk iteration and flag latching
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      car_q <= '0;
      res <= '0;
      res_zero <= 1'b0;
      res_neg <= 1'b0;
      idx <= '0;
      cy <= 1'b0;
      zacc <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sum_q <= PW'(sum_in);
      car_q <= PW'(carry_in);
      idx <= '0;
      cy <= 1'b0;
      zacc <= 1'b1;
    end else if (state == RUN) begin
      res <= res_d;
      cy <= cout;
      zacc <= zacc & ~nz;
      idx <= last ? '0 : idx + 1'b1;
      if (last) begin
        res_zero <= zacc & ~nz;
        res_neg <= res_d[W-1];
      end
    end
  end
endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: vector table, scoreboard and corner sequences for csa_resolver
module tb_csa_resolver;
  typedef struct {
    logic [64:0] s, c, r;
    logic z, n;
  } vec_t;
  typedef struct {
    logic [64:0] r;
    logic z, n;
  } exp_t;
  logic clk = 0, rst = 1;
  logic [64:0] sum_in = '0, carry_in = '0;
  logic in_valid = 0, out_ready = 1;
  logic in_ready, res_zero, res_neg, out_valid;
  logic [64:0] res;
  int checks = 0, errors = 0, cyc = 0;
  exp_t sb[$];
  exp_t cur_exp, e;
  vec_t tv[7];

  csa_resolver #(.LENGTH(32), .CHUNK(16)) dut (
    .clk(clk),
    .rst(rst),
    .sum_in(sum_in),
    .carry_in(carry_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .res(res),
    .res_zero(res_zero),
    .res_neg(res_neg),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) sb.push_back(cur_exp);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", {64'b0, out_valid}, 65'd0);
      else begin
        e = sb.pop_front();
        chk("res", res, e.r);
        chk("res_zero", {64'b0, res_zero}, {64'b0, e.z});
        chk("res_neg", {64'b0, res_neg}, {64'b0, e.n});
      end
    end
  end

  task automatic accept();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", {64'b0, in_ready}, 65'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
  endtask

  task automatic op(input logic [64:0] s, input logic [64:0] c, input exp_t x);
    int lat;
    cur_exp = x;
    sum_in = s;
    carry_in = c;
    in_valid = 1;
    accept();
    in_valid = 0;
    wait_ov(lat);
    chk("latency", 65'(lat), 65'd5);
    @(posedge clk);
    #1;
  endtask

  task automatic rnd();
    logic [64:0] s, c, r;
    s = {1'($urandom), $urandom, $urandom};
    c = {1'($urandom), $urandom, $urandom};
    r = s + c;
    sum_in = s;
    carry_in = c;
    cur_exp = '{r: r, z: (r == 65'd0), n: r[64]};
  endtask

  initial begin
    int lat, n, t, tprev;
    tv[0] = '{s: 65'h1_FFFF_FFFF_FFFF_FFFF, c: 65'd1, r: 65'd0, z: 1, n: 0};
    tv[1] = '{s: 65'h0_0000_0000_0000_FFFF, c: 65'd1, r: 65'h0_0000_0000_0001_0000, z: 0, n: 0};
    tv[2] = '{s: 65'h1_FFFF_FFFF_FFFF_FFFB, c: 65'd2, r: 65'h1_FFFF_FFFF_FFFF_FFFD, z: 0, n: 1};
    tv[3] = '{s: 65'd0, c: 65'd0, r: 65'd0, z: 1, n: 0};
    tv[4] = '{s: 65'h1_0000_0000_0000_0000, c: 65'h0_8000_0000_0000_0000, r: 65'h1_8000_0000_0000_0000, z: 0, n: 1};
    tv[5] = '{s: 65'h0_0000_FFFF_0000_FFFF, c: 65'h0_0000_0001_0000_0001, r: 65'h0_0001_0000_0001_0000, z: 0, n: 0};
    tv[6] = '{s: 65'h0_FFFF_FFFF_FFFF_FFFF, c: 65'd1, r: 65'h1_0000_0000_0000_0000, z: 0, n: 1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {64'b0, out_valid}, 65'd0);
    chk("rst_in_ready", {64'b0, in_ready}, 65'd0);
    chk("rst_res", res, 65'd0);
    chk("rst_zero", {64'b0, res_zero}, 65'd0);
    chk("rst_neg", {64'b0, res_neg}, 65'd0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("idle_in_ready", {64'b0, in_ready}, 65'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) op(tv[i].s, tv[i].c, '{r: tv[i].r, z: tv[i].z, n: tv[i].n});

    out_ready = 0;
    cur_exp = '{r: 65'h14, z: 0, n: 0};
    sum_in = 65'h0A;
    carry_in = 65'h0A;
    in_valid = 1;
    accept();
    sum_in = 65'h3;
    carry_in = 65'h4;
    cur_exp = '{r: 65'h7, z: 0, n: 0};
    wait_ov(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {64'b0, out_valid}, 65'd1);
      chk("hold_in_ready", {64'b0, in_ready}, 65'd0);
      chk("hold_res", res, 65'h14);
    end
    @(posedge clk);
    #1 out_ready = 1;
    accept();
    in_valid = 0;
    wait_ov(lat);
    chk("post_hold_latency", 65'(lat), 65'd5);
    @(posedge clk);
    #1;

    cur_exp = '{r: 65'h2, z: 0, n: 0};
    sum_in = 65'h1;
    carry_in = 65'h1;
    in_valid = 1;
    accept();
    in_valid = 0;
    @(posedge clk);
    #1 rst = 1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrun_rst_out_valid", {64'b0, out_valid}, 65'd0);
    chk("midrun_rst_res", res, 65'd0);
    chk("midrun_rst_in_ready", {64'b0, in_ready}, 65'd0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("after_rst_in_ready", {64'b0, in_ready}, 65'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_stale", {64'b0, out_valid}, 65'd0);
    end
    @(posedge clk);
    #1;

    out_ready = 1;
    rnd();
    in_valid = 1;
    tprev = 0;
    for (int k = 0; k < 100; k++) begin
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk("rand_accept_timeout", {64'b0, in_ready}, 65'd1);
      t = cyc;
      if (k > 0) chk("accept_period", 65'(t - tprev), 65'd7);
      tprev = t;
      @(posedge clk);
      #1;
      if (k == 99) in_valid = 0;
      else rnd();
    end
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", 65'(sb.size()), 65'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
